// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for decode: counts in-flight writes per register and
// stalls issue on RAW hazards or when a destination counter is saturated.
module reg_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 2**REG_ADDR_W,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  use_a,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic                  use_b,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_accept,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    pend_reg  [NUM_REGS];
  logic [CNT_W-1:0]    pend_next [NUM_REGS];
  logic                err_reg;
  logic                err_next;
  logic [NUM_REGS-1:0] underflow_vec;
  logic [NUM_REGS-1:0] overflow_vec;
  logic [CNT_W-1:0]    eff_a;
  logic [CNT_W-1:0]    eff_b;
  logic [CNT_W-1:0]    eff_d;
  logic                haz_a;
  logic                haz_b;
  logic                sat_d;
  logic                inc;
  logic                dec;

  // Effective count nets out a write retiring this very cycle (write-first regfile).
  assign eff_a = pend_reg[src_a]
               - CNT_W'(wb_valid && (wb_dest == src_a) && (pend_reg[src_a] != '0));
  assign eff_b = pend_reg[src_b]
               - CNT_W'(wb_valid && (wb_dest == src_b) && (pend_reg[src_b] != '0));
  assign eff_d = pend_reg[issue_dest]
               - CNT_W'(wb_valid && (wb_dest == issue_dest) && (pend_reg[issue_dest] != '0));

  assign haz_a = use_a && (src_a != '0) && (eff_a != '0);
  assign haz_b = use_b && (src_b != '0) && (eff_b != '0);
  assign sat_d = issue_writes && (issue_dest != '0) && (eff_d == CNT_MAX);

  assign stall        = issue_valid && !flush && (haz_a || haz_b || sat_d);
  assign issue_accept = issue_valid && !stall && !flush;

  assign inc = issue_accept && issue_writes && (issue_dest != '0);
  assign dec = wb_valid && (wb_dest != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pend_next[gi]     = '0;
        assign underflow_vec[gi] = 1'b0;
        assign overflow_vec[gi]  = 1'b0;
        assign busy_mask[gi]     = 1'b0;
      end else begin : g_track
        logic inc_hit;
        logic dec_hit;

        assign inc_hit = inc && (issue_dest == REG_ADDR_W'(gi));
        assign dec_hit = dec && (wb_dest == REG_ADDR_W'(gi));

        assign underflow_vec[gi] = !flush && dec_hit && !inc_hit && (pend_reg[gi] == '0);
        assign overflow_vec[gi]  = !flush && inc_hit && !dec_hit && (pend_reg[gi] == CNT_MAX);

        // A matching inc and dec cancel; saturating ends hold their value.
        assign pend_next[gi] = flush ? '0 :
                               (inc_hit && !dec_hit && !overflow_vec[gi]) ? pend_reg[gi] + CNT_W'(1) :
                               (dec_hit && !inc_hit && !underflow_vec[gi]) ? pend_reg[gi] - CNT_W'(1) :
                               pend_reg[gi];

        assign busy_mask[gi] = (pend_reg[gi] != '0);
      end
    end
  endgenerate

  assign err_next = err_reg || (|underflow_vec) || (|overflow_vec);
  assign err      = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend_reg[i] <= '0;
      err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) pend_reg[i] <= pend_next[i];
      err_reg <= err_next;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) overflow_vec == '0);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios then random traffic,
// all checked against a per-register outstanding-write count model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_writes, use_a, use_b, wb_valid, flush;
  logic [4:0]  issue_dest, src_a, src_b, wb_dest;
  logic        stall, issue_accept, err;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  int pend_m [32];
  bit err_m;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
    .use_a(use_a), .src_a(src_a), .use_b(use_b), .src_b(src_b),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall), .issue_accept(issue_accept), .busy_mask(busy_mask), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Writes still outstanding on r once any retirement this cycle is counted.
  function automatic int eff_m(input int r);
    int e = pend_m[r];
    if (wb_valid && int'(wb_dest) == r && r != 0 && e > 0) e--;
    return e;
  endfunction

  function automatic bit stall_m();
    bit hz = 1'b0;
    if (use_a && src_a != 0 && eff_m(int'(src_a)) > 0) hz = 1'b1;
    if (use_b && src_b != 0 && eff_m(int'(src_b)) > 0) hz = 1'b1;
    if (issue_writes && issue_dest != 0 && eff_m(int'(issue_dest)) == 3) hz = 1'b1;
    return issue_valid && !flush && hz;
  endfunction

  function automatic logic [31:0] busy_m();
    logic [31:0] bm = '0;
    for (int r = 1; r < 32; r++) if (pend_m[r] != 0) bm[r] = 1'b1;
    return bm;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) pend_m[r] = 0;
    err_m = 1'b0;
  endtask

  task automatic drive(input bit iv, input bit iw, input int d, input bit ua, input int sa,
                       input bit ub, input int sb, input bit wv, input int wd, input bit fl);
    issue_valid = iv; issue_writes = iw; issue_dest = 5'(d);
    use_a = ua; src_a = 5'(sa); use_b = ub; src_b = 5'(sb);
    wb_valid = wv; wb_dest = 5'(wd); flush = fl;
  endtask

  // Compare all outputs against the model mid-cycle.
  task automatic settle();
    bit s;
    @(negedge clk);
    s = stall_m();
    check("stall", stall, s);
    check("accept", issue_accept, issue_valid && !s && !flush);
    check("busy", busy_mask, busy_m());
    check("err", err, err_m);
    $display("txn %0d: iv=%0b w=%0b d=%0d a=%0b/%0d b=%0b/%0d wb=%0b/%0d fl=%0b -> stall=%0b acc=%0b busy=%h err=%0b",
             txn, issue_valid, issue_writes, issue_dest, use_a, src_a, use_b, src_b,
             wb_valid, wb_dest, flush, stall, issue_accept, busy_mask, err);
    txn++;
  endtask

  task automatic advance();
    bit acc;
    acc = issue_valid && !stall_m() && !flush;
    @(posedge clk);
    if (flush) begin
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
    end else begin
      if (acc && issue_writes && issue_dest != 0) pend_m[issue_dest]++;
      if (wb_valid && wb_dest != 0) begin
        if (pend_m[wb_dest] == 0) err_m = 1'b1;
        else pend_m[wb_dest]--;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 4));
  endfunction

  initial begin
    clear_model();
    rst = 1'b1;
    drive(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    #2;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_accept", issue_accept, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // RAW on r8: stall next cycle, cleared by same-cycle write-back
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 0, 0, 1, 8, 0, 0, 0, 0, 0); settle();
    check("raw_stall", stall, 1'b1); advance();
    drive(1, 0, 0, 1, 8, 0, 0, 1, 8, 0); settle();
    check("raw_wb_stall", stall, 1'b0);
    check("raw_wb_accept", issue_accept, 1'b1); advance();

    // r0 never tracked
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); settle();
    check("r0_stall", stall, 1'b0);
    check("r0_busy", busy_mask, 32'h0); advance();

    // Saturate r3
    repeat (3) begin drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); settle(); advance(); end
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); settle();
    check("sat_stall", stall, 1'b1); advance();
    drive(1, 1, 3, 0, 0, 0, 0, 1, 3, 0); settle();
    check("sat_wb_stall", stall, 1'b0); advance();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); settle();
    check("sat_still3", stall, 1'b1); advance();

    // Flush with busy = r4,r8 and a wb to r4 ignored
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); settle(); advance();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 1); settle();
    check("pre_flush_busy", busy_mask, 32'h0000_0110); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("flush_busy", busy_mask, 32'h0);
    check("flush_err", err, 1'b0); advance();

    // Underflow on r9 sets sticky err
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); settle(); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("uf_err", err, 1'b1); advance();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0); settle();
    check("uf_err_sticky", err, 1'b1);
    check("pend5_busy", busy_mask, 32'h0000_0020); advance();

    // Asynchronous reset mid-stall
    rst = 1'b1;
    #1;
    check("arst_busy", busy_mask, 32'h0);
    check("arst_err", err, 1'b0);
    check("arst_stall", stall, 1'b0);
    check("arst_accept", issue_accept, 1'b1);
    clear_model();
    #1;
    rst = 1'b0;

    repeat (400) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_writes = 1'($urandom_range(0, 1));
      issue_dest   = pick();
      use_a        = 1'($urandom_range(0, 1));
      src_a        = pick();
      use_b        = 1'($urandom_range(0, 1));
      src_b        = pick();
      wb_valid     = 1'($urandom_range(0, 1));
      wb_dest      = pick();
      flush        = ($urandom_range(0, 31) == 0);
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
